mem_responder: RTL and testbench

Byte-addressed memory responder serving the 8-bit multicycle datapath's memory port: it accepts the datapath's read/write requests on `adr`/`writedata`, returns bytes on `memdata`, and signals completion with a one-cycle `memready` pulse. Storage is word-organised and little-endian, so the four sequential byte fetches that assemble a 32-bit instruction return its bytes low to high. A side loader port preloads whole words for program images.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_array.sv | 46 ++++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding, op/lane constants and sizing helpers for the
// mem_responder slice.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int LANE_W = 8;
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    function automatic int mem_aw(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            LANE0:   be = 4'b0001;
            LANE1:   be = 4'b0010;
            LANE2:   be = 4'b0100;
            LANE3:   be = 4'b1000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Datapath memory port plus word loader, bundled for the responder and its driver.
interface mem_responder_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
);
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;
    logic             memready;
    logic             ld_en;
    logic [AW-1:0]    ld_adr;
    logic [31:0]      ld_data;

    modport master (
        output memread, memwrite, adr, writedata, ld_en, ld_adr, ld_data,
        input  memdata, memready
    );

    modport slave (
        input  memread, memwrite, adr, writedata, ld_en, ld_adr, ld_data,
        output memdata, memready
    );
endinterface

// File: rtl/mem_array.sv
// Word-organised storage: registered byte read, byte-enabled write, and a
// full-word loader port that overrides a same-word byte write.
module mem_array import mem_pkg::*; #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = mem_aw(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_idx_i,
    input  logic [1:0]        rd_lane_i,
    output logic [LANE_W-1:0] rd_byte_o,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_idx_i,
    input  logic [3:0]        wr_be_i,
    input  logic [LANE_W-1:0] wr_byte_i,
    input  logic              ld_en_i,
    input  logic [AW-1:0]     ld_idx_i,
    input  logic [31:0]       ld_word_i
);
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [LANE_W-1:0] rd_byte_q;
    logic              wr_live;

    assign wr_live = wr_en_i && !(ld_en_i && (ld_idx_i == wr_idx_i));

    always_ff @(posedge clk) begin
        if (wr_live) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_i[i]) mem_q[wr_idx_i][i*LANE_W +: LANE_W] <= wr_byte_i;
            end
        end
        if (ld_en_i) mem_q[ld_idx_i] <= ld_word_i;
    end

    // Read register is reset so the port presents zero until the first read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_byte_q <= '0;
        end else if (rd_en_i) begin
            rd_byte_q <= mem_q[rd_idx_i][{rd_lane_i, 3'b000} +: LANE_W];
        end
    end

    assign rd_byte_o = rd_byte_q;
endmodule

// File: rtl/mem_responder.sv
// Byte-addressed memory responder with one-cycle memready pulse.
// Define MEM_WAIT_EN to insert WAIT wait states; otherwise latency is fixed at 1.
module mem_responder #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT        = 2
) (
    input logic           clk,
    input logic           rst,
    mem_responder_if.slave bus
);
    import mem_pkg::*;

    localparam int AW = mem_aw(DEPTH_WORDS);

    mem_state_t        state_q, state_d;
    logic              op_q, op_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic [1:0]        lane_q, lane_d;
    logic [LANE_W-1:0] wdata_q, wdata_d;
    logic              memready_q;
    logic [LANE_W-1:0] rd_byte;
    logic              req;
    logic              rd_en, wr_en, ld_en;
    logic              unused_bits;

    assign req         = bus.memread | bus.memwrite;
    assign unused_bits = ^{bus.adr, bus.writedata};

`ifdef MEM_WAIT_EN
    logic [3:0] cnt_q, cnt_d;
`else
    logic unused_wait;
    assign unused_wait = |WAIT;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        widx_d  = widx_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
`ifdef MEM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            mem_pkg::IDLE: begin
                if (req) begin
                    // Write wins when both strobes are high.
                    op_d    = bus.memwrite ? OP_WR : OP_RD;
                    widx_d  = bus.adr[AW+1:2];
                    lane_d  = bus.adr[1:0];
                    wdata_d = bus.writedata[LANE_W-1:0];
`ifdef MEM_WAIT_EN
                    if (WAIT == 0) begin
                        state_d = mem_pkg::RESP;
                    end else begin
                        state_d = mem_pkg::WAIT;
                        cnt_d   = 4'(WAIT - 1);
                    end
`else
                    state_d = mem_pkg::RESP;
`endif
                end
            end
            mem_pkg::WAIT: begin
`ifdef MEM_WAIT_EN
                if (cnt_q == 4'd0) state_d = mem_pkg::RESP;
                else               cnt_d   = cnt_q - 4'd1;
`else
                state_d = mem_pkg::IDLE;
`endif
            end
            mem_pkg::RESP: state_d = mem_pkg::IDLE;
            default:       state_d = mem_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= mem_pkg::IDLE;
            op_q       <= OP_RD;
            memready_q <= 1'b0;
`ifdef MEM_WAIT_EN
            cnt_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            memready_q <= (state_d == mem_pkg::RESP);
`ifdef MEM_WAIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        widx_q  <= widx_d;
        lane_q  <= lane_d;
        wdata_q <= wdata_d;
    end

    // Read is launched on the edge entering RESP; write commits on the edge leaving it.
    assign rd_en = !rst && (state_q != mem_pkg::RESP) && (state_d == mem_pkg::RESP) && (op_d == OP_RD);
    assign wr_en = !rst && (state_q == mem_pkg::RESP) && (op_q == OP_WR);
    assign ld_en = !rst && bus.ld_en;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en_i  (rd_en),
        .rd_idx_i (widx_d),
        .rd_lane_i(lane_d),
        .rd_byte_o(rd_byte),
        .wr_en_i  (wr_en),
        .wr_idx_i (widx_q),
        .wr_be_i  (lane_be(lane_q)),
        .wr_byte_i(wdata_q),
        .ld_en_i  (ld_en),
        .ld_idx_i (bus.ld_adr),
        .ld_word_i(bus.ld_data)
    );

    assign bus.memready = memready_q;
    assign bus.memdata  = WIDTH'(rd_byte);
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array model.
module tb_mem_responder;
    localparam int DEPTH  = 64;
    localparam int WAITN  = 2;
    localparam int DEPTH2 = 16;
    localparam int WAIT2  = 1;
`ifdef MEM_WAIT_EN
    localparam int LAT  = WAITN;
    localparam int LAT2 = WAIT2;
`else
    localparam int LAT  = 0;
    localparam int LAT2 = 0;
`endif
    localparam int P = LAT + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(8), .AW(6)) m();
    mem_responder_if #(.WIDTH(8), .AW(4)) m2();

    mem_responder #(.WIDTH(8), .DEPTH_WORDS(DEPTH), .WAIT(WAITN)) dut (
        .clk(clk), .rst(rst), .bus(m)
    );
    mem_responder #(.WIDTH(8), .DEPTH_WORDS(DEPTH2), .WAIT(WAIT2)) dut2 (
        .clk(clk), .rst(rst), .bus(m2)
    );

    logic [31:0] mem_m [DEPTH];
    logic [7:0]  md_m;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [7:0] a);
        int ai = int'(a);
        int w  = (ai / 4) % DEPTH;
        int l  = ai % 4;
        return 8'(mem_m[w] >> (8 * l));
    endfunction

    task automatic ld(input logic [5:0] idx, input logic [31:0] word);
        m.ld_en = 1'b1; m.ld_adr = idx; m.ld_data = word;
        @(negedge clk);
        m.ld_en = 1'b0;
        mem_m[idx] = word;
    endtask

    task automatic ld2(input logic [3:0] idx, input logic [31:0] word);
        m2.ld_en = 1'b1; m2.ld_adr = idx; m2.ld_data = word;
        @(negedge clk);
        m2.ld_en = 1'b0;
    endtask

    // One request; optional loader pulse lands on the edge that ends RESP.
    task automatic xact(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit ldc, input logic [5:0] lidx, input logic [31:0] lword);
        int k;
        int w = (int'(a) / 4) % DEPTH;
        int l = int'(a) % 4;
        m.memread = rd; m.memwrite = wr; m.adr = a; m.writedata = wd;
        @(negedge clk);
        m.memread = 1'b0; m.memwrite = 1'b0;
        k = 0;
        while (!m.memready && k < LAT + 4) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, LAT);
        if (!wr) md_m = mbyte(a);
        chk(wr ? "wr_hold" : "rdata", m.memdata, md_m);
        if (ldc) begin
            m.ld_en = 1'b1; m.ld_adr = lidx; m.ld_data = lword;
        end
        @(negedge clk);
        m.ld_en = 1'b0;
        if (wr) mem_m[w][8*l +: 8] = wd;
        if (ldc) mem_m[lidx] = lword;
        chk("ready_pulse", m.memready, 1'b0);
    endtask

    task automatic rd2(input logic [7:0] a, input logic [7:0] exp);
        int k;
        m2.memread = 1'b1; m2.adr = a;
        @(negedge clk);
        m2.memread = 1'b0;
        k = 0;
        while (!m2.memready && k < LAT2 + 4) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_lat", k, LAT2);
        chk("wrap_data", m2.memdata, exp);
        @(negedge clk);
    endtask

    logic [7:0] lane_exp [4];
    logic [7:0] iso_exp  [4];

    initial begin
        int op;
        logic [7:0] a, wd;
        logic [5:0] lidx;
        bit conf;
        {m.memread, m.memwrite, m.adr, m.writedata, m.ld_en, m.ld_adr, m.ld_data} = '0;
        {m2.memread, m2.memwrite, m2.adr, m2.writedata, m2.ld_en, m2.ld_adr, m2.ld_data} = '0;
        md_m = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", m.memready, 1'b0);
        chk("reset_data", m.memdata, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) ld(6'(i), $urandom);

        // Lane order within a little-endian word.
        ld(6'd0, 32'h8C030044);
        lane_exp[0] = 8'h44; lane_exp[1] = 8'h00; lane_exp[2] = 8'h03; lane_exp[3] = 8'h8C;
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 6'd0, 32'd0);
            chk("lane_read", m.memdata, lane_exp[i]);
        end

        // Byte write leaves neighbouring lanes alone.
        ld(6'd5, 32'h11223344);
        xact(1'b0, 1'b1, 8'h15, 8'hAB, 1'b0, 6'd0, 32'd0);
        iso_exp[0] = 8'h44; iso_exp[1] = 8'hAB; iso_exp[2] = 8'h22; iso_exp[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 1'b0, 8'h14 + 8'(i), 8'h00, 1'b0, 6'd0, 32'd0);
            chk("byte_iso", m.memdata, iso_exp[i]);
        end

        // Both strobes: write wins.
        xact(1'b1, 1'b1, 8'h08, 8'h5A, 1'b0, 6'd0, 32'd0);
        xact(1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 6'd0, 32'd0);
        chk("simul_read", m.memdata, 8'h5A);

        // Loader beats a committing write to the same word.
        xact(1'b0, 1'b1, 8'h31, 8'hEE, 1'b1, 6'd12, 32'hCAFEF00D);
        xact(1'b1, 1'b0, 8'h31, 8'h00, 1'b0, 6'd0, 32'd0);
        chk("ld_priority", m.memdata, 8'hF0);

        // Held read: one pulse per P cycles.
        m.memread = 1'b1; m.adr = 8'h16;
        for (int k = 0; k < 3 * P; k++) begin
            @(negedge clk);
            chk("held_ready", m.memready, (k % P) == LAT);
            if ((k % P) == LAT) begin
                md_m = mbyte(8'h16);
                chk("held_data", m.memdata, md_m);
            end
        end
        m.memread = 1'b0;

        // Reset in the cycle after accept drops the write; loader ignored in reset.
        ld(6'd8, 32'h77665544);
        m.memwrite = 1'b1; m.adr = 8'h20; m.writedata = 8'hFF;
        @(negedge clk);
        m.memwrite = 1'b0;
        rst = 1'b1;
        m.ld_en = 1'b1; m.ld_adr = 6'd8; m.ld_data = 32'hDEADBEEF;
        @(negedge clk);
        rst = 1'b0; m.ld_en = 1'b0;
        md_m = 8'h00;
        chk("rst_mid_data", m.memdata, 8'h00);
        for (int k = 0; k < LAT + 3; k++) begin
            chk("rst_mid_ready", m.memready, 1'b0);
            @(negedge clk);
        end
        xact(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 6'd0, 32'd0);
        chk("rst_mid_mem", m.memdata, 8'h44);

        // Word index wraps modulo depth on the 16-word instance.
        ld2(4'd1, 32'hA1B2C3D4);
        rd2(8'h44, 8'hD4);
        rd2(8'h47, 8'hA1);

        for (int it = 0; it < 60; it++) begin
            op   = $urandom_range(0, 3);
            a    = 8'($urandom);
            wd   = 8'($urandom);
            conf = 1'($urandom_range(0, 1));
            lidx = conf ? a[7:2] : 6'($urandom);
            case (op)
                0: xact(1'b1, 1'b0, a, wd, 1'b0, lidx, 32'd0);
                1: begin
                    xact(1'b0, 1'b1, a, wd, conf, lidx, $urandom);
                    xact(1'b1, 1'b0, a, 8'h00, 1'b0, 6'd0, 32'd0);
                end
                2: xact(1'b1, 1'b1, a, wd, 1'b0, lidx, 32'd0);
                default: ld(lidx, $urandom);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
